// File: rtl/mem_arb_pkg.sv
// Shared encodings for the single-port SRAM arbiter: requester ids, FSM states, read tag.
package mem_arb_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned BE_W             = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LS   = 2'd1,
    REQ_IF   = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_t;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    req_id_t id;
    logic    rd;
  } rd_tag_t;

  function automatic logic is_core_read(input rd_tag_t tag);
    return tag.rd && (tag.id == REQ_LS || tag.id == REQ_IF);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive cycles the debug requester lost arbitration.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  assign at_limit_c = (count == CNT_W'(LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one synchronous SRAM between load/store, fetch and debug,
// with a halt/drain FSM that hands the memory exclusively to debug.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [BE_W-1:0]   ls_be,
  input  logic [31:0]       ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_halt_req,
  output logic              ls_gnt,
  output logic              if_gnt,
  output logic              dbg_gnt,
  output logic              ls_rvalid,
  output logic              if_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              core_stall,
  output logic              dbg_halt_ack,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] state;
  logic [1:0] state_d;
  req_id_t    gnt_id;
  rd_tag_t    tag;
  rd_tag_t    tag_d;
  logic       starve_max_c;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ls_addr[31:ADDR_W+2], ls_addr[1:0],
                              if_addr[31:ADDR_W+2], if_addr[1:0],
                              dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .inc        (dbg_req && !dbg_gnt),
    .clr        (dbg_gnt || !dbg_req),
    .at_limit_c (starve_max_c)
  );

  // Grant selection; reset forces the memory idle.
  always_comb begin
    gnt_id = REQ_NONE;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (dbg_req && starve_max_c) gnt_id = REQ_DBG;
          else if (ls_req)             gnt_id = REQ_LS;
          else if (if_req)             gnt_id = REQ_IF;
          else if (dbg_req)            gnt_id = REQ_DBG;
        end
        ST_DRAIN, ST_HALTED: begin
          if (dbg_req) gnt_id = REQ_DBG;
        end
        default: gnt_id = REQ_NONE;
      endcase
    end
  end

  assign ls_gnt  = (gnt_id == REQ_LS);
  assign if_gnt  = (gnt_id == REQ_IF);
  assign dbg_gnt = (gnt_id == REQ_DBG);
  assign mem_en  = ls_gnt || if_gnt || dbg_gnt;

  // SRAM port mux for the winning requester.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    case (gnt_id)
      REQ_LS: begin
        mem_addr  = ls_addr[ADDR_W+1:2];
        mem_wdata = ls_wdata;
        mem_we    = ls_we ? ls_be : BE_W'(0);
      end
      REQ_IF: begin
        mem_addr = if_addr[ADDR_W+1:2];
      end
      REQ_DBG: begin
        mem_addr  = dbg_addr[ADDR_W+1:2];
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we ? {BE_W{1'b1}} : BE_W'(0);
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  always_comb begin
    tag_d    = '{id: REQ_NONE, rd: 1'b0};
    tag_d.id = gnt_id;
    tag_d.rd = mem_en && (mem_we == BE_W'(0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag <= '{id: REQ_NONE, rd: 1'b0};
    end else begin
      tag <= tag_d;
    end
  end

  assign ls_rvalid  = tag.rd && (tag.id == REQ_LS);
  assign if_rvalid  = tag.rd && (tag.id == REQ_IF);
  assign dbg_rvalid = tag.rd && (tag.id == REQ_DBG);
  assign rdata      = mem_rdata;

  assign core_stall = (ls_req && !ls_gnt) || (if_req && !if_gnt) || (state != ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_d;
    end
  end

  // Drain completes once no core read is left outstanding past this cycle.
  always_comb begin
    state_d = state;
    case (state)
      ST_RUN: begin
        if (dbg_halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!dbg_halt_req)             state_d = ST_RUN;
        else if (!is_core_read(tag_d)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!dbg_halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_halt_ack <= 1'b0;
    end else begin
      dbg_halt_ack <= (state_d == ST_HALTED);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, read tags, starvation, halt/drain, reset, aliasing.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_halt_req;
  logic        ls_gnt, if_gnt, dbg_gnt;
  logic        ls_rvalid, if_rvalid, dbg_rvalid;
  logic [31:0] rdata;
  logic        core_stall, dbg_halt_ack;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int unsigned total;
  int unsigned passed;

  mem_arbiter #(.ADDR_W(14), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .if_req(if_req), .if_addr(if_addr),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_halt_req(dbg_halt_req),
    .ls_gnt(ls_gnt), .if_gnt(if_gnt), .dbg_gnt(dbg_gnt),
    .ls_rvalid(ls_rvalid), .if_rvalid(if_rvalid), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .core_stall(core_stall), .dbg_halt_ack(dbg_halt_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    dbg_halt_req = 1'b0;
    mem_rdata = 32'hCAFE_F00D;

    // Reset forces everything idle even with requests pending
    #1;
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_ack", 32'(dbg_halt_ack), 32'd0);

    tick();
    ls_req = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
    reset = 1'b0;

    // ls read 0x10 and if read 0x20 together
    tick();
    ls_req = 1'b1; ls_addr = 32'h10;
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    chk("t1_c0_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("t1_c0_if_gnt", 32'(if_gnt), 32'd0);
    chk("t1_c0_mem_addr", 32'(mem_addr), 32'd4);
    chk("t1_c0_mem_we", 32'(mem_we), 32'd0);
    chk("t1_c0_stall", 32'(core_stall), 32'd1);
    tick();
    ls_req = 1'b0;
    #1;
    chk("t1_c1_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("t1_c1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_c1_mem_addr", 32'(mem_addr), 32'd8);
    chk("t1_c1_stall", 32'(core_stall), 32'd0);
    chk("t1_c1_rdata", rdata, 32'hCAFE_F00D);
    tick();
    if_req = 1'b0;
    #1;
    chk("t1_c2_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_c2_ls_rvalid", 32'(ls_rvalid), 32'd0);

    // ls byte write: lane 2 only, no rvalid afterwards
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0100; ls_addr = 32'h7; ls_wdata = 32'hAABB_CCDD;
    #1;
    chk("t2_mem_we", 32'(mem_we), 32'h4);
    chk("t2_mem_addr", 32'(mem_addr), 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'hAABB_CCDD);
    tick();
    ls_req = 1'b0;
    #1;
    chk("t2_no_rvalid", 32'(ls_rvalid), 32'd0);

    // write with empty byte mask behaves as a read
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h0; ls_addr = 32'h14;
    #1;
    chk("t3_mem_we", 32'(mem_we), 32'd0);
    chk("t3_mem_addr", 32'(mem_addr), 32'd5);
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    #1;
    chk("t3_rvalid", 32'(ls_rvalid), 32'd1);

    // all three requesting, counter below limit: ls wins
    tick();
    ls_req = 1'b1; ls_addr = 32'h0; if_req = 1'b1; if_addr = 32'h4;
    dbg_req = 1'b1; dbg_addr = 32'h8;
    #1;
    chk("t4_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("t4_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("t4_stall", 32'(core_stall), 32'd1);
    tick();
    ls_req = 1'b0; if_req = 1'b0; dbg_req = 1'b0;

    // starvation: dbg loses 4 cycles to if, wins on the 5th
    tick();
    if_req = 1'b1; if_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("t5_deny%0d_dbg_gnt", i), 32'(dbg_gnt), 32'd0);
      chk($sformatf("t5_deny%0d_if_gnt", i), 32'(if_gnt), 32'd1);
      tick();
    end
    #1;
    chk("t5_win_dbg_gnt", 32'(dbg_gnt), 32'd1);
    chk("t5_win_if_gnt", 32'(if_gnt), 32'd0);
    chk("t5_win_mem_addr", 32'(mem_addr), 32'h10);
    chk("t5_win_stall", 32'(core_stall), 32'd1);
    tick();
    #1;
    chk("t5_after_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("t5_after_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("t5_after_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0; dbg_req = 1'b0;

    // halt request in the cycle an if read is granted
    tick();
    if_req = 1'b1; if_addr = 32'h30; dbg_halt_req = 1'b1;
    #1;
    chk("t6_t0_if_gnt", 32'(if_gnt), 32'd1);
    chk("t6_t0_ack", 32'(dbg_halt_ack), 32'd0);
    tick();
    if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h50;
    #1;
    chk("t6_t1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t6_t1_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("t6_t1_stall", 32'(core_stall), 32'd1);
    chk("t6_t1_ack", 32'(dbg_halt_ack), 32'd0);
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_t2_ack", 32'(dbg_halt_ack), 32'd1);
    chk("t6_t2_dbg_gnt", 32'(dbg_gnt), 32'd1);
    chk("t6_t2_mem_we", 32'(mem_we), 32'hF);
    chk("t6_t2_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t6_t2_ls_gnt", 32'(ls_gnt), 32'd0);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_halt_req = 1'b0;
    #1;
    chk("t6_t3_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("t6_t3_ack", 32'(dbg_halt_ack), 32'd1);
    chk("t6_t3_ls_gnt", 32'(ls_gnt), 32'd0);
    tick();
    #1;
    chk("t6_t4_ack", 32'(dbg_halt_ack), 32'd0);
    chk("t6_t4_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("t6_t4_stall", 32'(core_stall), 32'd0);
    tick();
    ls_req = 1'b0;

    // reset right after an ls read grant drops its rvalid
    tick();
    ls_req = 1'b1; ls_addr = 32'h100;
    #1;
    chk("t7_ls_gnt", 32'(ls_gnt), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("t7_rst_rvalid", 32'(ls_rvalid), 32'd0);
    chk("t7_rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("t7_rst_mem_en", 32'(mem_en), 32'd0);
    tick();
    reset = 1'b0; ls_req = 1'b0;
    #1;
    chk("t7_rel_rvalid", 32'(ls_rvalid), 32'd0);
    tick();
    #1;
    chk("t7_rel2_rvalid", 32'(ls_rvalid), 32'd0);

    // upper address bits alias; back in RUN after reset
    ls_req = 1'b1; ls_addr = 32'h0001_0004;
    #1;
    chk("t8_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("t8_mem_addr", 32'(mem_addr), 32'd1);
    chk("t8_stall", 32'(core_stall), 32'd0);
    tick();
    ls_req = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
